alu_iterative_muldiv: RTL
=========================

Name: alu_iterative_muldiv

Overview:
- Parametrised, registered successor to the datapath ALU for the MIPS core.
- Provides the bitwise, add/sub and compare operations with a fixed 1-cycle latency.
- Adds an iterative unsigned multiply and divide unit with architectural HI/LO registers and a start/busy/done handshake.
- Sits in the EX stage; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4); also the iteration count for MULTU/DIVU.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled only when busy=0.
- select  input  4  opcode; sampled with start.
- first  input  WIDTH  operand A; sampled with start.
- second  input  WIDTH  operand B; sampled with start.
- out  output  WIDTH  registered result; valid while done=1 and held until the next completion.
- zero  output  1  registered; 1 iff out==0; updated with out.
- ovf  output  1  registered; signed overflow of ADD/SUB, 0 for all other ops.
- div0  output  1  registered; 1 iff the last completed op was DIVU with second==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  1 in RUN and DONE states.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0. out, hi, lo = 0. zero=1. ovf, div0, busy, done = 0. Any in-flight op is discarded.
- Opcodes:
  - 0000 AND (bitwise).
  - 0001 OR (bitwise).
  - 0010 ADD (mod 2^WIDTH, ovf = signed overflow).
  - 0011 SLTU (unsigned A<B -> 1 else 0, zero-extended).
  - 0110 SUB (A-B mod 2^WIDTH, ovf = signed overflow).
  - 0111 SLT (signed A<B -> 1 else 0).
  - 1100 NOR.
  - 1000 MULTU.
  - 1001 DIVU.
  - 1010 MFHI (out=hi).
  - 1011 MFLO (out=lo).
  - Any other code: out=0, completes as a 1-cycle op.
- State machine IDLE / RUN / DONE:
  - IDLE & start & 1-cycle op -> DONE. The result is computed from the sampled operands and registered at that edge.
  - IDLE & start & (MULTU|DIVU) -> RUN. Operands are latched, the product/remainder accumulator is cleared, and counter=WIDTH-1.
  - RUN: one shift-add (MULTU) or one restoring shift-subtract (DIVU) iteration per cycle. When counter==0 the final iteration is written and the state goes to DONE. Otherwise counter decrements.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
- Latency, counted from the accepting edge to the cycle in which done=1:
  - 1-cycle ops: 1 cycle.
  - MULTU/DIVU: WIDTH+1 cycles (RUN occupies exactly WIDTH cycles).
- Throughput: a new start is accepted in the cycle after DONE at the earliest. start while busy=1 is ignored and not queued.
- MULTU completion: {hi,lo} = A*B as a 2*WIDTH-bit unsigned product; out=lo.
- DIVU completion: lo = A/B, hi = A%B, out=lo.
- DIVU with second==0: runs the full WIDTH iterations. Result lo = all ones, hi = first, div0=1.
- hi/lo change only at MULTU/DIVU completion or reset. MFHI/MFLO read the values from before any concurrent request.
- zero and ovf are updated at every completion together with out. div0 is cleared by any non-DIVU completion.
- ovf: ADD sets it when A and B have the same sign and the result sign differs. SUB sets it when A and B have different signs and the result sign differs from A.

Test Plan:
- Reset asserted mid-MULTU (cycle 10 of RUN): outputs return immediately to reset values. Next start ADD 3+4 gives done 1 cycle later, out=7, zero=0, hi=lo=0.
- WIDTH=32: ADD 0x7FFFFFFF+1 -> out=0x80000000, ovf=1. SUB 5-5 -> out=0, zero=1, ovf=0. SLT 0xFFFFFFFF,1 -> 1. SLTU same operands -> 0. NOR 0,0 -> 0xFFFFFFFF.
- MULTU 0xFFFFFFFF*0xFFFFFFFF: busy for 33 cycles, done in cycle 33 after accept, hi=0xFFFFFFFE, lo=0x00000001. Then MFHI -> out=0xFFFFFFFE after 1 cycle.
- DIVU 100/7 -> lo=14, hi=2, div0=0. DIVU 9/0 -> lo=0xFFFFFFFF, hi=9, div0=1. Next AND op clears div0.
- start pulsed every cycle during a DIVU with changing select/operands: exactly one done pulse and result equal to the original DIVU only. The second request is accepted only in the cycle after DONE.
- Illegal opcode 1111 -> done after 1 cycle, out=0, zero=1, hi/lo unchanged.

Source files
------------

// File: rtl/alu_iterative_muldiv.sv
// alu_iterative_muldiv
//   EX-stage ALU for the MIPS core. Bitwise, add/sub and compare ops finish
//   one cycle after acceptance. MULTU/DIVU run one shift-add or one restoring
//   shift-subtract step per cycle and then write the HI/LO registers.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request, sampled only while busy=0
//   select        opcode, sampled with start
//   first/second  operands A/B, sampled with start
//   out           registered result, held until the next completion
//   zero          out==0, updated with out
//   ovf           signed overflow of ADD/SUB, 0 otherwise
//   div0          last completed op was DIVU with B==0
//   hi, lo        architectural HI/LO
//   busy          high in RUN and DONE
//   done          one-cycle completion pulse
module alu_iterative_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] second,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ovf,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   opa, opb;
  logic               is_div;
  // Multiply: full product. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic               is_long;

  logic [WIDTH-1:0]   sum, dif, alu_res, quo;
  logic               alu_ovf;
  logic [WIDTH:0]     r2, r2_sub;
  logic               ge;

  assign is_long = (select == OP_MULTU) || (select == OP_DIVU);
  assign idx     = cnt[IDX_W-1:0];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = is_long ? RUN : DONE;
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- single-cycle ALU ----------------
  assign sum = first + second;
  assign dif = first - second;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (select)
      OP_AND:  alu_res = first & second;
      OP_OR:   alu_res = first | second;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (first[WIDTH-1] == second[WIDTH-1]) && (sum[WIDTH-1] != first[WIDTH-1]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (first < second)};
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (first[WIDTH-1] != second[WIDTH-1]) && (dif[WIDTH-1] != first[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(first) < $signed(second))};
      OP_NOR:  alu_res = ~(first | second);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // ---------------- iteration step (MSB first, bit idx) ----------------
  // Restoring divide: with B==0 every trial subtract succeeds, so the
  // quotient becomes all ones and the remainder collects A unchanged.
  always_comb begin
    r2     = {acc[2*WIDTH-1:WIDTH], opa[idx]};
    r2_sub = r2 - {1'b0, opb};
    ge     = (r2 >= {1'b0, opb});
    quo    = acc[WIDTH-1:0];
    quo[idx] = ge;
    if (is_div)
      acc_nxt = {(ge ? r2_sub[WIDTH-1:0] : r2[WIDTH-1:0]), quo};
    else
      acc_nxt = {acc[2*WIDTH-2:0], 1'b0} + (opb[idx] ? {{WIDTH{1'b0}}, opa} : '0);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      acc    <= '0;
      out    <= '0;
      zero   <= 1'b1;
      ovf    <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (is_long) begin
            opa    <= first;
            opb    <= second;
            is_div <= select[0];
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH-1);
          end else begin
            out  <= alu_res;
            zero <= (alu_res == '0);
            ovf  <= alu_ovf;
            div0 <= 1'b0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (cnt == '0) begin
            hi   <= acc_nxt[2*WIDTH-1:WIDTH];
            lo   <= acc_nxt[WIDTH-1:0];
            out  <= acc_nxt[WIDTH-1:0];
            zero <= (acc_nxt[WIDTH-1:0] == '0);
            ovf  <= 1'b0;
            div0 <= is_div && (opb == '0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
